// File: rtl/ad7266_scan_ctrl_pkg.sv
// Shared types and defaults for the AD7266-class dual-SAR scan controller.
package ad7266_scan_ctrl_pkg;

  localparam int unsigned AddrW        = 3;
  localparam int unsigned DefClkDiv    = 2;
  localparam int unsigned DefFrameBits = 16;
  localparam int unsigned DefLeadBits  = 2;
  localparam int unsigned DefDataBits  = 12;
  localparam int unsigned DefNumCh     = 6;
  localparam int unsigned DefQuietCyc  = 4;

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StQuiet} state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [AddrW-1:0] next_ch(input logic [AddrW-1:0] ch,
                                               input int unsigned num_ch);
    return (ch == AddrW'(num_ch - 1)) ? '0 : ch + 1'b1;
  endfunction

endpackage

// File: rtl/ad7266_scan_ctrl_sclk_div.sv
// SCLK generator for one CS_N-low frame: CLK_DIV cycles low then CLK_DIV high per bit.
module ad7266_scan_ctrl_sclk_div #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned BitW       = $clog2(FRAME_BITS + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  output logic            sclk_o,
  output logic            rise_o,
  output logic [BitW-1:0] bit_idx_o,
  output logic            frame_done_o
);

  localparam int unsigned DivW = $clog2(CLK_DIV + 1);

  logic [DivW-1:0] div_q;
  logic            phase_q;
  logic [BitW-1:0] bit_q;
  logic            last_half;

  assign last_half = (div_q == DivW'(CLK_DIV - 1));

  // Counters are held cleared outside the frame so every frame starts on a low half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
    end else if (!en_i) begin
      div_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
    end else if (last_half) begin
      div_q   <= '0;
      phase_q <= ~phase_q;
      if (phase_q) bit_q <= bit_q + 1'b1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  always_comb begin
    sclk_o       = ~en_i | phase_q;
    rise_o       = en_i & ~phase_q & last_half;
    frame_done_o = en_i & phase_q & last_half & (bit_q == BitW'(FRAME_BITS - 1));
    bit_idx_o    = bit_q;
  end

endmodule

// File: rtl/ad7266_scan_ctrl.sv
// Dual-SAR ADC channel-range scanner delivering tagged A/B result pairs on a valid/ready stream.
module ad7266_scan_ctrl
  import ad7266_scan_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DefClkDiv,
  parameter int unsigned FRAME_BITS = DefFrameBits,
  parameter int unsigned LEAD_BITS  = DefLeadBits,
  parameter int unsigned DATA_BITS  = DefDataBits,
  parameter int unsigned NUM_CH     = DefNumCh,
  parameter int unsigned QUIET_CYC  = DefQuietCyc
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 cont_en,
  input  logic [2:0]           ch_first,
  input  logic [2:0]           ch_last,
  input  logic                 range_sel,
  input  logic                 sgl_diff_n,
  output logic                 SCLK,
  output logic                 CS_N,
  output logic                 RANGE,
  output logic                 SGL_DIFN,
  output logic                 A2,
  output logic                 A1,
  output logic                 A0,
  input  logic                 DOUTA,
  input  logic                 DOUTB,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           out_ch,
  output logic [DATA_BITS-1:0] out_data_a,
  output logic [DATA_BITS-1:0] out_data_b,
  output logic                 busy,
  output logic                 overrun
);

  localparam int unsigned BitW = $clog2(FRAME_BITS + 1);
  localparam int unsigned CntW = $clog2(max_u(CLK_DIV, QUIET_CYC) + 1);

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [AddrW-1:0]     ch_q, first_q, last_q, out_ch_q;
  logic                 range_q, sgl_q;
  logic [DATA_BITS-1:0] sr_a_q, sr_b_q, out_a_q, out_b_q;
  logic                 out_valid_q, overrun_q;
  logic                 shift_en, rise, frame_done;
  logic [BitW-1:0]      bit_idx;
  logic                 setup_done, quiet_done, scan_last, in_window;

  ad7266_scan_ctrl_sclk_div #(
    .CLK_DIV   (CLK_DIV),
    .FRAME_BITS(FRAME_BITS),
    .BitW      (BitW)
  ) u_sclk_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (shift_en),
    .sclk_o      (SCLK),
    .rise_o      (rise),
    .bit_idx_o   (bit_idx),
    .frame_done_o(frame_done)
  );

  assign setup_done = (state_q == StSetup) && (cnt_q == CntW'(CLK_DIV - 1));
  assign quiet_done = (state_q == StQuiet) && (cnt_q == CntW'(QUIET_CYC - 1));
  assign scan_last  = (ch_q == last_q);
  assign in_window  = (bit_idx >= BitW'(LEAD_BITS)) && (bit_idx < BitW'(LEAD_BITS + DATA_BITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StSetup;
      StSetup: if (setup_done) state_d = StShift;
      StShift: if (frame_done) state_d = StQuiet;
      StQuiet: if (quiet_done) state_d = (scan_last && !cont_en) ? StIdle : StSetup;
      default: state_d = StIdle;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q        <= '0;
      first_q     <= '0;
      last_q      <= '0;
      range_q     <= 1'b0;
      sgl_q       <= 1'b1;
      sr_a_q      <= '0;
      sr_b_q      <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      if (state_q == StIdle && start) begin
        ch_q    <= ch_first;
        first_q <= ch_first;
        last_q  <= ch_last;
        range_q <= range_sel;
        sgl_q   <= sgl_diff_n;
      end else if (quiet_done) begin
        ch_q <= scan_last ? first_q : next_ch(ch_q, NUM_CH);
      end
      if (rise && in_window) begin
        sr_a_q <= {sr_a_q[DATA_BITS-2:0], DOUTA};
        sr_b_q <= {sr_b_q[DATA_BITS-2:0], DOUTB};
      end
      // A fresh result always wins; an unconsumed one is lost and flagged.
      overrun_q <= frame_done && out_valid_q && !out_ready;
      if (frame_done) begin
        out_valid_q <= 1'b1;
        out_ch_q    <= ch_q;
        out_a_q     <= sr_a_q;
        out_b_q     <= sr_b_q;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    shift_en     = (state_q == StShift);
    CS_N         = ~shift_en;
    busy         = (state_q != StIdle);
    {A2, A1, A0} = ch_q;
    RANGE        = range_q;
    SGL_DIFN     = sgl_q;
    out_valid    = out_valid_q;
    out_ch       = out_ch_q;
    out_data_a   = out_a_q;
    out_data_b   = out_b_q;
    overrun      = overrun_q;
  end

endmodule
